// File: rtl/fft_iter_core.sv
// Sequential radix-2 DIT FFT of runtime size N = 2**cfg_log2n: bit-reversed load,
// log2N in-place butterfly passes on one butterfly unit, natural-order unload.
module fft_iter_core #(
    parameter int MAX_LOG2N = 7,
    parameter int DW        = 17,
    parameter int TW        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           cfg_log2n,
    input  logic                 cfg_scale,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*DW-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DW-1:0]      out_data,
    output logic                 out_last,
    output logic [MAX_LOG2N-2:0] tw_addr,
    input  logic [TW-1:0]        tw_re,
    input  logic [TW-1:0]        tw_im,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int AW   = MAX_LOG2N;
    localparam int NMAX = 2 ** AW;
    localparam int EW   = DW + 2;
    localparam int PW   = DW + TW + 2;

    localparam logic signed [PW-1:0] RND     = PW'(2 ** (TW - 2));
    localparam logic signed [EW-1:0] SAT_MAX = EW'(2 ** (DW - 1) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = -EW'(2 ** (DW - 1));

    typedef enum logic [1:0] {IDLE, LOAD, CALC, UNLOAD} state_t;

    state_t          state, state_nxt;
    logic [3:0]      log2n_q;
    logic            scale_q;
    logic [AW:0]     cnt_q;
    logic [3:0]      pass_q;
    logic [AW-2:0]   bfly_q;
    logic [2*DW-1:0] ram [NMAX];

    logic            cfg_ok;
    logic [AW:0]     n_pts, n_last;
    logic            in_fire, load_last, bfly_end, calc_last, unload_end;
    logic [AW-1:0]   wr_addr;

    assign cfg_ok     = (cfg_log2n != 4'd0) && (cfg_log2n <= 4'(MAX_LOG2N));
    assign n_pts      = (AW + 1)'(1) << log2n_q;
    assign n_last     = n_pts - 1'b1;
    assign in_fire    = (state == LOAD) && in_valid;
    assign load_last  = in_fire && (cnt_q == n_last);
    assign bfly_end   = ({1'b0, bfly_q} == n_last[AW:1]);
    assign calc_last  = (state == CALC) && bfly_end && (pass_q == log2n_q);
    assign unload_end = (cnt_q == n_last);

    // Bit-reverse the low log2n bits of the load index.
    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < AW; i++)
            if (i < int'(log2n_q)) wr_addr[int'(log2n_q) - 1 - i] = cnt_q[i];
    end

    // Butterfly addressing: a = g*2*half + j, c = a + half.
    logic [3:0]    sm1;
    logic [AW-2:0] hmask, j_n, tw_c;
    logic [AW-1:0] bfly_w, half_w, a_addr, c_addr;

    assign sm1    = pass_q - 4'd1;
    assign hmask  = ~({(AW - 1){1'b1}} << sm1);
    assign j_n    = bfly_q & hmask;
    assign bfly_w = {1'b0, bfly_q};
    assign half_w = AW'(1) << sm1;
    assign a_addr = ((bfly_w >> sm1) << pass_q) | {1'b0, j_n};
    assign c_addr = a_addr | half_w;
    assign tw_c   = j_n << (4'(MAX_LOG2N) - pass_q);

    logic signed [DW-1:0] a_re, a_im, c_re, c_im;
    logic signed [TW-1:0] w_re, w_im;
    logic signed [PW-1:0] p_re, p_im, tr_w, ti_w;
    logic signed [EW-1:0] t_re, t_im, s_re, s_im, d_re, d_im;
    logic signed [EW-1:0] s_re_sc, s_im_sc, d_re_sc, d_im_sc;
    logic [2*DW-1:0]      wa_data, wc_data;

    assign a_re = ram[a_addr][2*DW-1:DW];
    assign a_im = ram[a_addr][DW-1:0];
    assign c_re = ram[c_addr][2*DW-1:DW];
    assign c_im = ram[c_addr][DW-1:0];
    assign w_re = tw_re;
    assign w_im = tw_im;

    assign p_re = PW'(c_re) * PW'(w_re) - PW'(c_im) * PW'(w_im);
    assign p_im = PW'(c_re) * PW'(w_im) + PW'(c_im) * PW'(w_re);
    assign tr_w = (p_re + RND) >>> (TW - 1);
    assign ti_w = (p_im + RND) >>> (TW - 1);
    assign t_re = tr_w[EW-1:0];
    assign t_im = ti_w[EW-1:0];

    assign s_re = EW'(a_re) + t_re;
    assign s_im = EW'(a_im) + t_im;
    assign d_re = EW'(a_re) - t_re;
    assign d_im = EW'(a_im) - t_im;

    assign s_re_sc = scale_q ? (s_re >>> 1) : s_re;
    assign s_im_sc = scale_q ? (s_im >>> 1) : s_im;
    assign d_re_sc = scale_q ? (d_re >>> 1) : d_re;
    assign d_im_sc = scale_q ? (d_im >>> 1) : d_im;

    function automatic logic [DW-1:0] sat(input logic signed [EW-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DW-1:0];
        if (x < SAT_MIN) return SAT_MIN[DW-1:0];
        return x[DW-1:0];
    endfunction

    assign wa_data = {sat(s_re_sc), sat(s_im_sc)};
    assign wc_data = {sat(d_re_sc), sat(d_im_sc)};

    // NOTE: the sample RAM has no reset; every location used is written in LOAD before it is read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_fire) begin
                ram[wr_addr] <= in_data;
            end else if (state == CALC) begin
                ram[a_addr] <= wa_data;
                ram[c_addr] <= wc_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            err     <= 1'b0;
            log2n_q <= '0;
            scale_q <= 1'b0;
            cnt_q   <= '0;
            pass_q  <= '0;
            bfly_q  <= '0;
        end else begin
            state <= state_nxt;
            err   <= (state == IDLE) && start && !cfg_ok;
            case (state)
                IDLE: if (start && cfg_ok) begin
                    log2n_q <= cfg_log2n;
                    scale_q <= cfg_scale;
                    cnt_q   <= '0;
                end
                LOAD: if (in_valid) begin
                    if (load_last) begin
                        cnt_q  <= '0;
                        pass_q <= 4'd1;
                        bfly_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CALC: if (bfly_end) begin
                    bfly_q <= '0;
                    pass_q <= pass_q + 4'd1;
                end else begin
                    bfly_q <= bfly_q + 1'b1;
                end
                UNLOAD: if (out_ready) cnt_q <= cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every output driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        tw_addr   = '0;
        case (state)
            IDLE:   if (start && cfg_ok) state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (load_last) state_nxt = CALC;
            end
            CALC: begin
                tw_addr = tw_c;
                if (calc_last) state_nxt = UNLOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = ram[cnt_q[AW-1:0]];
                out_last  = unload_end;
                if (out_ready && unload_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == UNLOAD) && out_ready && unload_end;

endmodule
